alu_seq: RTL and testbench

Execute-stage sequencer for the kt8 datapath, sitting directly upstream of the 8-bit ALU. It accepts one command per valid/ready handshake, reads operands from a 4-entry 8-bit register file (or an immediate), drives the ALU's a/b/op inputs, captures the ALU result and writes it back to the destination register. Commands are fully serialised, so there are no data hazards.

---
 rtl/alu_seq.sv | 120 ++++++++++++
 tb/tb_alu_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Execute-stage sequencer for the kt8 datapath: accepts one command, drives the ALU, writes the result back.
// Optional zero flag register built when KT8_ZFLAG_EN is defined; otherwise z_o is tied low.
`timescale 1ns/1ps
module alu_seq (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [3:0] cmd_op_i,
  input  logic [1:0] cmd_dst_i,
  input  logic [1:0] cmd_srca_i,
  input  logic [1:0] cmd_srcb_i,
  input  logic       cmd_useimm_i,
  input  logic [7:0] cmd_imm_i,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  output logic [3:0] alu_op_o,
  input  logic [7:0] alu_r_i,
  output logic [7:0] result_o,
  output logic       done_o,
  output logic       z_o,
  input  logic [1:0] rd_sel_i,
  output logic [7:0] rd_data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] op_q, op_d;
  logic [1:0] dst_q, dst_d;
  logic [7:0] result_q, result_d;
  logic [7:0] regs_q [4];
  logic [7:0] regs_d [4];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    dst_d       = dst_q;
    result_d    = result_q;
    regs_d      = regs_q;
    cmd_ready_o = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          a_d     = regs_q[cmd_srca_i];
          b_d     = cmd_useimm_i ? cmd_imm_i : regs_q[cmd_srcb_i];
          op_d    = cmd_op_i;
          dst_d   = cmd_dst_i;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_r_i;
        state_d  = WB;
      end
      WB: begin
        done_o         = 1'b1;
        regs_d[dst_q]  = result_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      dst_q    <= '0;
      result_q <= '0;
      for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      result_q <= result_d;
      for (int unsigned i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign alu_a_o   = a_q;
  assign alu_b_o   = b_q;
  assign alu_op_o  = op_q;
  assign result_o  = result_q;
  assign rd_data_o = regs_q[rd_sel_i];

`ifdef KT8_ZFLAG_EN
  logic z_q, z_d;

  // Flag samples the same ALU result that result_o captures at the EXEC edge.
  always_comb begin
    z_d = z_q;
    if (state_q == EXEC) z_d = (alu_r_i == 8'h00);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) z_q <= 1'b0;
    else       z_q <= z_d;
  end

  assign z_o = z_q;
`else
  assign z_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus random commands against a register-file model.
`timescale 1ns/1ps
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_dst, cmd_srca, cmd_srcb;
  logic       cmd_useimm;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a, alu_b, alu_r;
  logic [3:0] alu_op;
  logic [7:0] result;
  logic       done, z;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned last_acc = 0;

  logic [7:0] model_regs [4];
  logic       model_z;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_dst_i(cmd_dst), .cmd_srca_i(cmd_srca), .cmd_srcb_i(cmd_srcb),
    .cmd_useimm_i(cmd_useimm), .cmd_imm_i(cmd_imm),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_r_i(alu_r),
    .result_o(result), .done_o(done), .z_o(z),
    .rd_sel_i(rd_sel), .rd_data_o(rd_data)
  );

  // Stand-in for the kt8 ALU; unlisted opcodes produce 0.
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd8:    return b;
      4'd12:   return a + 8'd1;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_r = alu_fn(alu_op, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reg(input string tag, input int idx);
    rd_sel = idx[1:0];
    #1;
    check(tag, {24'h0, rd_data}, {24'h0, model_regs[idx]});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
    model_z = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the write-back edge.
  task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] srca,
                       input logic [1:0] srcb, input logic useimm, input logic [7:0] imm, input bit hold);
    logic [7:0] ea, eb, er;
    int unsigned waited;
    ea = model_regs[srca];
    eb = useimm ? imm : model_regs[srcb];
    er = alu_fn(op, ea, eb);
    cmd_op = op; cmd_dst = dst; cmd_srca = srca; cmd_srcb = srcb;
    cmd_useimm = useimm; cmd_imm = imm; cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    last_acc = cyc + 1;
    #1;
    if (!hold) cmd_valid = 1'b0;
    @(negedge clk);
    check("exec_ready", {31'h0, cmd_ready}, 32'd0);
    check("exec_done", {31'h0, done}, 32'd0);
    check("alu_a", {24'h0, alu_a}, {24'h0, ea});
    check("alu_b", {24'h0, alu_b}, {24'h0, eb});
    check("alu_op", {28'h0, alu_op}, {28'h0, op});
    @(negedge clk);
    `ifdef KT8_ZFLAG_EN
    model_z = (er == 8'h00);
    `endif
    check("wb_done", {31'h0, done}, 32'd1);
    check("wb_ready", {31'h0, cmd_ready}, 32'd0);
    check("result", {24'h0, result}, {24'h0, er});
    check("z_flag", {31'h0, z}, {31'h0, model_z});
    check("alu_a_hold", {24'h0, alu_a}, {24'h0, ea});
    @(negedge clk);
    model_regs[dst] = er;
    check("post_done", {31'h0, done}, 32'd0);
    check("post_ready", {31'h0, cmd_ready}, 32'd1);
    check_reg("wb_reg", int'(dst));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc1;
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 4'd8; cmd_dst = 2'd1; cmd_srca = 2'd0; cmd_srcb = 2'd0;
    cmd_useimm = 1'b1; cmd_imm = 8'h33; rd_sel = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    // Reset wins over a simultaneous valid command.
    check("rst_ready", {31'h0, cmd_ready}, 32'd1);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_alu_a", {24'h0, alu_a}, 32'd0);
    check("rst_alu_b", {24'h0, alu_b}, 32'd0);
    check("rst_alu_op", {28'h0, alu_op}, 32'd0);
    check("rst_result", {24'h0, result}, 32'd0);
    check("rst_z", {31'h0, z}, 32'd0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) check_reg("rst_reg", i);
    @(negedge clk);

    issue(4'd8, 2'd1, 2'd0, 2'd0, 1'b1, 8'h5A, 1'b0);
    issue(4'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'hA6, 1'b0);

    issue(4'd8, 2'd1, 2'd0, 2'd0, 1'b1, 8'h0F, 1'b0);
    issue(4'd12, 2'd1, 2'd1, 2'd0, 1'b0, 8'h00, 1'b1);
    acc1 = last_acc;
    issue(4'd12, 2'd1, 2'd1, 2'd0, 1'b0, 8'h00, 1'b0);
    check("b2b_gap", last_acc - acc1, 32'd3);
    check("b2b_value", {24'h0, model_regs[1]}, 32'h11);

    issue(4'd8, 2'd0, 2'd0, 2'd0, 1'b1, 8'h03, 1'b0);
    issue(4'd8, 2'd3, 2'd0, 2'd0, 1'b1, 8'h05, 1'b0);
    issue(4'd1, 2'd0, 2'd0, 2'd3, 1'b0, 8'h00, 1'b0);

    issue(4'd8, 2'd1, 2'd0, 2'd0, 1'b1, 8'h44, 1'b0);
    issue(4'd15, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 1'b0);

    // Abandon a command in EXEC.
    cmd_op = 4'd8; cmd_dst = 2'd2; cmd_useimm = 1'b1; cmd_imm = 8'h77; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("abort_ready", {31'h0, cmd_ready}, 32'd1);
    check("abort_done", {31'h0, done}, 32'd0);
    check("abort_result", {24'h0, result}, 32'd0);
    check("abort_alu_b", {24'h0, alu_b}, 32'd0);
    check("abort_z", {31'h0, z}, 32'd0);
    check_reg("abort_reg2", 2);
    @(negedge clk);
    check("abort_done_late", {31'h0, done}, 32'd0);
    for (int i = 0; i < 4; i++) check_reg("abort_reg", i);

    for (int k = 0; k < 40; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      issue(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) check_reg("final_reg", i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
